// File: rtl/mac_rx.sv
// Receive-side Ethernet MAC: strips preamble/SFD, filters on destination MAC,
// captures source MAC and EtherType, and streams the payload with an FCS verdict.
//
// state  | meaning
// IDLE   | waiting for the first preamble byte
// PRE    | inside preamble, counting 0x55 bytes (max 7) until SFD
// DST    | shifting in destination MAC, compared on the 6th byte
// SRC    | shifting in source MAC into shadow register
// TYPE   | EtherType bytes; header outputs commit on the 2nd byte
// DATA   | payload (and FCS) through the delay line
// DROP   | discarding the rest of a rejected burst
module mac_rx #(
  parameter logic [47:0] P_LOCAL_MAC = 48'h00_00_00_00_00_00,
  parameter int          P_CRC_CHECK = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_GMII_data,
  input  logic        i_GMII_valid,
  output logic [47:0] o_recv_source_mac,
  output logic [15:0] o_recv_type,
  output logic [7:0]  o_recv_data,
  output logic        o_recv_valid,
  output logic        o_recv_last,
  output logic        o_recv_crc_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DST,
    S_SRC,
    S_TYPE,
    S_DATA,
    S_DROP
  } state_t;

  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_GOOD  = 32'hDEBB_20E3;
  // The FCS trails the payload by 4 bytes, so 5 bytes must be held before the
  // oldest is known to be payload; without FCS one byte of lookahead finds last.
  localparam logic [2:0]  DLY_DEPTH = (P_CRC_CHECK != 0) ? 3'd5 : 3'd1;
  localparam int          OLDEST    = (P_CRC_CHECK != 0) ? 4 : 0;

  state_t      state_q, state_d;
  logic [2:0]  pre_cnt_q, pre_cnt_d;
  logic [2:0]  hdr_cnt_q, hdr_cnt_d;
  logic [39:0] dst_q, dst_d;
  logic [47:0] src_q, src_d;
  logic [7:0]  type_hi_q, type_hi_d;
  logic [7:0]  dly_q [5];
  logic [7:0]  dly_d [5];
  logic [2:0]  dly_cnt_q, dly_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [47:0] src_mac_q, src_mac_d;
  logic [15:0] type_q, type_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic [31:0] crc_upd;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] r;
    r = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  assign crc_upd = crc_byte(crc_q, i_GMII_data);

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    hdr_cnt_d = hdr_cnt_q;
    dst_d     = dst_q;
    src_d     = src_q;
    type_hi_d = type_hi_q;
    dly_d     = dly_q;
    dly_cnt_d = dly_cnt_q;
    crc_d     = crc_q;
    src_mac_d = src_mac_q;
    type_d    = type_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    last_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_GMII_valid) begin
          if (i_GMII_data == 8'h55) begin
            state_d   = S_PRE;
            pre_cnt_d = 3'd1;
          end else begin
            state_d = S_DROP;
          end
        end
      end

      S_PRE: begin
        if (!i_GMII_valid) begin
          state_d = S_IDLE;
        end else if (i_GMII_data == 8'hD5) begin
          state_d   = S_DST;
          hdr_cnt_d = 3'd0;
          crc_d     = CRC_INIT;
        end else if (i_GMII_data == 8'h55 && pre_cnt_q < 3'd7) begin
          pre_cnt_d = pre_cnt_q + 3'd1;
        end else begin
          state_d = S_DROP;
        end
      end

      S_DST: begin
        if (!i_GMII_valid) begin
          state_d = S_IDLE;
        end else begin
          crc_d = crc_upd;
          dst_d = {dst_q[31:0], i_GMII_data};
          if (hdr_cnt_q == 3'd5) begin
            hdr_cnt_d = 3'd0;
            if ({dst_q, i_GMII_data} == P_LOCAL_MAC || {dst_q, i_GMII_data} == BCAST_MAC) begin
              state_d = S_SRC;
            end else begin
              state_d = S_DROP;
            end
          end else begin
            hdr_cnt_d = hdr_cnt_q + 3'd1;
          end
        end
      end

      S_SRC: begin
        if (!i_GMII_valid) begin
          state_d = S_IDLE;
        end else begin
          crc_d = crc_upd;
          src_d = {src_q[39:0], i_GMII_data};
          if (hdr_cnt_q == 3'd5) begin
            hdr_cnt_d = 3'd0;
            state_d   = S_TYPE;
          end else begin
            hdr_cnt_d = hdr_cnt_q + 3'd1;
          end
        end
      end

      S_TYPE: begin
        if (!i_GMII_valid) begin
          state_d = S_IDLE;
        end else begin
          crc_d = crc_upd;
          if (hdr_cnt_q == 3'd0) begin
            type_hi_d = i_GMII_data;
            hdr_cnt_d = 3'd1;
          end else begin
            src_mac_d = src_q;
            type_d    = {type_hi_q, i_GMII_data};
            dly_cnt_d = 3'd0;
            state_d   = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (i_GMII_valid) begin
          crc_d    = crc_upd;
          dly_d[0] = i_GMII_data;
          for (int i = 1; i < 5; i++) begin
            dly_d[i] = dly_q[i-1];
          end
          // Fill count saturates at the line depth, so long frames never wrap.
          if (dly_cnt_q == DLY_DEPTH) begin
            valid_d = 1'b1;
            data_d  = dly_q[OLDEST];
          end else begin
            dly_cnt_d = dly_cnt_q + 3'd1;
          end
        end else begin
          state_d = S_IDLE;
          if (dly_cnt_q == DLY_DEPTH) begin
            valid_d = 1'b1;
            last_d  = 1'b1;
            data_d  = dly_q[OLDEST];
            err_d   = (P_CRC_CHECK != 0) && (crc_q != CRC_GOOD);
          end
        end
      end

      S_DROP: begin
        if (!i_GMII_valid) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      pre_cnt_q <= '0;
      hdr_cnt_q <= '0;
      dst_q     <= '0;
      src_q     <= '0;
      type_hi_q <= '0;
      for (int i = 0; i < 5; i++) begin
        dly_q[i] <= '0;
      end
      dly_cnt_q <= '0;
      crc_q     <= CRC_INIT;
      src_mac_q <= '0;
      type_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      hdr_cnt_q <= hdr_cnt_d;
      dst_q     <= dst_d;
      src_q     <= src_d;
      type_hi_q <= type_hi_d;
      for (int i = 0; i < 5; i++) begin
        dly_q[i] <= dly_d[i];
      end
      dly_cnt_q <= dly_cnt_d;
      crc_q     <= crc_d;
      src_mac_q <= src_mac_d;
      type_q    <= type_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      err_q     <= err_d;
    end
  end

  assign o_recv_source_mac = src_mac_q;
  assign o_recv_type       = type_q;
  assign o_recv_data       = data_q;
  assign o_recv_valid      = valid_q;
  assign o_recv_last       = last_q;
  assign o_recv_crc_err    = err_q;

endmodule

// File: tb/tb_mac_rx.sv
// Bench for mac_rx: FCS-checking and raw instances on a shared GMII stream,
// table vectors, timed tail sequences, reset abort and random frames vs a frame-level model.
module tb_mac_rx;

  typedef logic [7:0] q8_t[$];
  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       err;
  } rec_t;
  typedef struct {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] et;
    int          plen;
    logic [7:0]  first;
    bit          flip;
    int          exp_n;
    bit          exp_err;
    bit          exp_hdr;
  } vec_t;

  localparam logic [47:0] LOCAL = 48'h000A_3501_0203;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  gd;
  logic        gv;
  logic [47:0] src0, src1;
  logic [15:0] typ0, typ1;
  logic [7:0]  d0, d1;
  logic        v0, v1, l0, l1, e0o, e1o;

  int checks = 0;
  int errors = 0;
  rec_t q0[$], q1[$], x0[$], x1[$];
  logic [47:0] exp_src;
  logic [15:0] exp_type;

  always #5 clk = ~clk;

  mac_rx #(.P_LOCAL_MAC(LOCAL), .P_CRC_CHECK(1)) u_crc (
    .i_clk(clk), .i_rst(rst_n), .i_GMII_data(gd), .i_GMII_valid(gv),
    .o_recv_source_mac(src0), .o_recv_type(typ0), .o_recv_data(d0),
    .o_recv_valid(v0), .o_recv_last(l0), .o_recv_crc_err(e0o));

  mac_rx #(.P_LOCAL_MAC(LOCAL), .P_CRC_CHECK(0)) u_raw (
    .i_clk(clk), .i_rst(rst_n), .i_GMII_data(gd), .i_GMII_valid(gv),
    .o_recv_source_mac(src1), .o_recv_type(typ1), .o_recv_data(d1),
    .o_recv_valid(v1), .o_recv_last(l1), .o_recv_crc_err(e1o));

  always @(negedge clk) begin
    if (v0) q0.push_back(rec_t'({d0, l0, e0o}));
    else if (l0 || e0o) begin
      errors++;
      $display("FAIL strobe_crc last=%b err=%b while valid low, required 0", l0, e0o);
    end
    if (v1) q1.push_back(rec_t'({d1, l1, e1o}));
    else if (l1 || e1o) begin
      errors++;
      $display("FAIL strobe_raw last=%b err=%b while valid low, required 0", l1, e1o);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] crc_calc(input q8_t b);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic q8_t ramp(input logic [7:0] first, input int n);
    q8_t p;
    for (int i = 0; i < n; i++) p.push_back(8'(first + 8'(i)));
    return p;
  endfunction

  function automatic q8_t build(input int pre, input logic [7:0] sfd, input logic [47:0] dst,
                                input logic [47:0] src, input logic [15:0] et, input q8_t pl,
                                input bit fcs, input bit flip);
    q8_t f, body;
    logic [31:0] c;
    for (int i = 0; i < 6; i++) body.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) body.push_back(src[47-8*i -: 8]);
    body.push_back(et[15:8]);
    body.push_back(et[7:0]);
    foreach (pl[i]) body.push_back(pl[i]);
    if (fcs) begin
      c = ~crc_calc(body);
      for (int i = 0; i < 4; i++) body.push_back(c[8*i +: 8]);
      if (flip) body[body.size()-1] = body[body.size()-1] ^ 8'h80;
    end
    for (int i = 0; i < pre; i++) f.push_back(8'h55);
    f.push_back(sfd);
    foreach (body[i]) f.push_back(body[i]);
    return f;
  endfunction

  // Frame-level reference: what an ideal receiver delivers for one burst.
  function automatic void model_frame(input q8_t f);
    int k;
    int n;
    q8_t body, cov;
    logic [47:0] dst;
    logic [31:0] fcs;
    bit bad;
    k = 0;
    while (k < f.size() && f[k] == 8'h55) k++;
    if (k < 1 || k > 7 || k >= f.size() || f[k] != 8'hD5) return;
    for (int i = k + 1; i < f.size(); i++) body.push_back(f[i]);
    if (body.size() < 6) return;
    dst = {body[0], body[1], body[2], body[3], body[4], body[5]};
    if (dst != LOCAL && dst != 48'hFFFF_FFFF_FFFF) return;
    if (body.size() < 14) return;
    exp_src  = {body[6], body[7], body[8], body[9], body[10], body[11]};
    exp_type = {body[12], body[13]};
    n = body.size() - 14;
    for (int i = 0; i < n; i++) x1.push_back(rec_t'({body[14+i], i == n - 1, 1'b0}));
    if (n >= 5) begin
      for (int i = 0; i < 10 + n; i++) cov.push_back(body[i]);
      fcs = ~crc_calc(cov);
      bad = 1'b0;
      for (int j = 0; j < 4; j++) if (body[10+n+j] != fcs[8*j +: 8]) bad = 1'b1;
      for (int i = 0; i < n - 4; i++)
        x0.push_back(rec_t'({body[14+i], i == n - 5, (i == n - 5) && bad}));
    end
  endfunction

  task automatic drive_frame(input q8_t f, input int idle);
    foreach (f[i]) begin
      @(posedge clk); #1;
      gv = 1'b1;
      gd = f[i];
    end
    @(posedge clk); #1;
    gv = 1'b0;
    gd = 8'h00;
    for (int i = 1; i < idle; i++) @(posedge clk);
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".n_crc"}, 64'(q0.size()), 64'(x0.size()));
    for (int i = 0; i < x0.size() && i < q0.size(); i++) chk({tag, ".out_crc"}, 64'(q0[i]), 64'(x0[i]));
    chk({tag, ".n_raw"}, 64'(q1.size()), 64'(x1.size()));
    for (int i = 0; i < x1.size() && i < q1.size(); i++) chk({tag, ".out_raw"}, 64'(q1[i]), 64'(x1[i]));
    chk({tag, ".src_crc"}, 64'(src0), 64'(exp_src));
    chk({tag, ".type_crc"}, 64'(typ0), 64'(exp_type));
    chk({tag, ".src_raw"}, 64'(src1), 64'(exp_src));
    chk({tag, ".type_raw"}, 64'(typ1), 64'(exp_type));
    q0.delete(); q1.delete(); x0.delete(); x1.delete();
  endtask

  // Drives a frame and checks the two output cycles around the end of the burst.
  task automatic timed_tail(input string tag, input q8_t f, input bit inst,
                            input logic [7:0] a, input logic [7:0] b, input logic err_b);
    foreach (f[i]) begin
      @(posedge clk); #1;
      gv = 1'b1;
      gd = f[i];
    end
    @(posedge clk); #1;
    gv = 1'b0;
    gd = 8'h00;
    chk({tag, ".prev"}, inst ? 64'({v1, l1, d1}) : 64'({v0, l0, d0}), 64'({1'b1, 1'b0, a}));
    @(posedge clk); #1;
    chk({tag, ".last"}, inst ? 64'({v1, l1, e1o, d1}) : 64'({v0, l0, e0o, d0}),
        64'({1'b1, 1'b1, err_b, b}));
    @(posedge clk); #1;
    chk({tag, ".after"}, inst ? 64'(v1) : 64'(v0), 64'(0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".crc_hdr"}, 64'({typ0, src0}), 64'(0));
    chk({tag, ".crc_out"}, 64'({d0, v0, l0, e0o}), 64'(0));
    chk({tag, ".raw_hdr"}, 64'({typ1, src1}), 64'(0));
    chk({tag, ".raw_out"}, 64'({d1, v1, l1, e1o}), 64'(0));
  endtask

  initial begin
    vec_t vec[7];
    q8_t f, fb, pl;
    logic [47:0] SRC1;
    logic [47:0] dst, src;
    logic [15:0] et;
    logic [7:0] sfd;
    int pre, plen, cut;
    bit flip;

    SRC1 = 48'h1122_3344_5566;
    vec[0] = '{LOCAL,            SRC1,              16'h0800, 2,  8'h01, 1'b0, 2,  1'b0, 1'b1};
    vec[1] = '{48'hFFFF_FFFF_FFFF, 48'hA1A2_A3A4_A5A6, 16'h0800, 2,  8'h01, 1'b0, 2,  1'b0, 1'b1};
    vec[2] = '{48'h000A_3501_0204, 48'h0102_0304_0506, 16'h86DD, 2,  8'h01, 1'b0, 0,  1'b0, 1'b0};
    vec[3] = '{LOCAL,            SRC1,              16'h0800, 2,  8'h01, 1'b1, 2,  1'b1, 1'b1};
    vec[4] = '{LOCAL,            48'hDEAD_BEEF_0001, 16'h0806, 46, 8'h00, 1'b0, 46, 1'b0, 1'b1};
    vec[5] = '{LOCAL,            48'h0000_0000_0077, 16'h1234, 0,  8'h00, 1'b0, 0,  1'b0, 1'b1};
    vec[6] = '{LOCAL,            48'h5555_5555_5555, 16'hD5D5, 1,  8'hEE, 1'b1, 1,  1'b1, 1'b1};

    rst_n = 1'b0;
    gv = 1'b0;
    gd = 8'h00;
    exp_src = '0;
    exp_type = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int r = 0; r < 7; r++) begin
      f = build(7, 8'hD5, vec[r].dst, vec[r].src, vec[r].et, ramp(vec[r].first, vec[r].plen), 1'b1, vec[r].flip);
      model_frame(f);
      drive_frame(f, 1);
      repeat (4) @(posedge clk);
      chk($sformatf("tbl%0d.n", r), 64'(q0.size()), 64'(vec[r].exp_n));
      if (vec[r].exp_n > 0 && q0.size() > 0)
        chk($sformatf("tbl%0d.err", r), 64'(q0[q0.size()-1].err), 64'(vec[r].exp_err));
      if (vec[r].exp_hdr) begin
        chk($sformatf("tbl%0d.src", r), 64'(src0), 64'(vec[r].src));
        chk($sformatf("tbl%0d.type", r), 64'(typ0), 64'(vec[r].et));
      end
      compare_all($sformatf("tbl%0d", r));
    end

    // Good frame timing, then flipped-FCS timing.
    f = build(7, 8'hD5, LOCAL, SRC1, 16'h0800, ramp(8'h01, 2), 1'b1, 1'b0);
    model_frame(f);
    timed_tail("t1", f, 1'b0, 8'h01, 8'h02, 1'b0);
    repeat (2) @(posedge clk);
    compare_all("t1");
    f = build(7, 8'hD5, LOCAL, SRC1, 16'h0800, ramp(8'h01, 2), 1'b1, 1'b1);
    model_frame(f);
    timed_tail("t3", f, 1'b0, 8'h01, 8'h02, 1'b1);
    repeat (2) @(posedge clk);
    compare_all("t3");

    // Bad SFD, one idle cycle, then a good 46-byte frame.
    fb = build(7, 8'hD4, LOCAL, SRC1, 16'h0800, ramp(8'h01, 2), 1'b1, 1'b0);
    f  = build(7, 8'hD5, LOCAL, SRC1, 16'h0806, ramp(8'h00, 46), 1'b1, 1'b0);
    model_frame(fb);
    model_frame(f);
    drive_frame(fb, 1);
    drive_frame(f, 1);
    repeat (4) @(posedge clk);
    chk("t4.n", 64'(q0.size()), 64'(46));
    if (q0.size() == 46) chk("t4.lastbyte", 64'(q0[45]), 64'({8'h2D, 1'b1, 1'b0}));
    chk("t4.type", 64'(typ0), 64'(16'h0806));
    compare_all("t4");

    // Reset during payload byte 20, then a normal frame.
    f = build(7, 8'hD5, LOCAL, SRC1, 16'h0806, ramp(8'h00, 46), 1'b1, 1'b0);
    for (int i = 0; i < 42; i++) begin
      @(posedge clk); #1;
      gv = 1'b1;
      gd = f[i];
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    gv = 1'b0;
    gd = 8'h00;
    #1;
    chk_zero("t5.rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_src = '0;
    exp_type = '0;
    q0.delete(); q1.delete(); x0.delete(); x1.delete();
    @(posedge clk);
    model_frame(f);
    drive_frame(f, 1);
    repeat (4) @(posedge clk);
    compare_all("t5");

    // No-FCS payload AA BB CC on the raw instance.
    f = build(7, 8'hD5, LOCAL, SRC1, 16'h0800, '{8'hAA, 8'hBB, 8'hCC}, 1'b0, 1'b0);
    model_frame(f);
    timed_tail("t6", f, 1'b1, 8'hBB, 8'hCC, 1'b0);
    repeat (2) @(posedge clk);
    compare_all("t6");

    for (int b = 0; b < 12; b++) begin
      for (int j = 0; j < 3; j++) begin
        pre = ($urandom_range(0, 9) == 0) ? 8 : int'($urandom_range(1, 7));
        sfd = ($urandom_range(0, 9) == 0) ? 8'hD4 : 8'hD5;
        case ($urandom_range(0, 3))
          0, 1:    dst = LOCAL;
          2:       dst = 48'hFFFF_FFFF_FFFF;
          default: dst = {16'($urandom), $urandom};
        endcase
        src  = {16'($urandom), $urandom};
        et   = 16'($urandom);
        plen = int'($urandom_range(0, 20));
        pl.delete();
        for (int i = 0; i < plen; i++) pl.push_back(8'($urandom));
        flip = ($urandom_range(0, 3) == 0);
        f = build(pre, sfd, dst, src, et, pl, 1'b1, flip);
        if ($urandom_range(0, 4) == 0) begin
          cut = int'($urandom_range(1, f.size()));
          while (f.size() > cut) void'(f.pop_back());
        end
        model_frame(f);
        drive_frame(f, int'($urandom_range(1, 2)));
      end
      repeat (4) @(posedge clk);
      compare_all($sformatf("rnd%0d", b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
